pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch-address generator replacing the fixed sequential PC register. Holds the fetch PC, advances it on each accepted fetch, and predicts taken branches/jumps with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. Sits between EX (redirects, BTB training) and IF (address consumer, fetch handshake). Redirects that arrive while IF has a memory fetch in flight are buffered and applied when that fetch completes.

## Interface
- ADDR_W, 32, PC / target width in bits; must be greater than IDX_W+2.
- BTB_ENTRIES, 16, BTB depth; power of two, at least 2; IDX_W = log2(BTB_ENTRIES).
- RESET_PC, 0, PC value loaded on reset.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rdy  in  1  global enable; when 0, no state changes anywhere in the block.
- stall_i  in  1  pipeline stall; blocks sequential or predicted advance only.
- fetch_done_i  in  1  IF has the instruction for pc_o this cycle (cache hit or memory return).
- fetch_busy_i  in  1  IF has a non-abortable memory fetch outstanding for pc_o.
- redirect_i  in  1  EX mispredict or jump correction.
- redirect_pc_i  in  ADDR_W  corrected PC.
- upd_valid_i  in  1  BTB training strobe for a resolved control instruction.
- upd_pc_i  in  ADDR_W  PC of the resolved instruction.
- upd_target_i  in  ADDR_W  resolved target.
- upd_taken_i  in  1  resolved direction.
- pc_o  out  ADDR_W  current fetch PC.
- pred_taken_o  out  1  BTB predicts pc_o is taken.
- pred_pc_o  out  ADDR_W  predicted next PC for pc_o.
- pc_jump_enable_o  out  1  redirect applied this cycle; IF discards its current instruction.

## Operation
- Index is pc[IDX_W+1:2]. Tag is pc[ADDR_W-1:IDX_W+2]. Each entry holds valid, tag, target and a 2-bit counter.
- Lookup on pc_o is combinational. hit = valid and tag match. pred_taken_o = hit and counter[1]. pred_pc_o = target if pred_taken_o, else pc_o+4. The sum wraps modulo 2^ADDR_W.
- Redirect is acceptable when fetch_busy_i=0 or fetch_done_i=1. Otherwise the redirect is stored in the pending register (pend_v, pend_pc).
- Next-PC priority, evaluated only when rdy=1:
  - redirect_i and acceptable: load redirect_pc_i. pc_jump_enable_o=1. pend_v cleared.
  - pend_v and acceptable, with no new redirect: load pend_pc. pc_jump_enable_o=1. pend_v cleared.
  - fetch_done_i and !stall_i and !pend_v: load pred_pc_o.
  - otherwise hold.
- A new redirect_i while pend_v=1 and not acceptable overwrites pend_pc.
- pc_jump_enable_o is combinational. It is 0 during reset and whenever rdy=0.
- BTB update, when upd_valid_i and rdy:
  - Hit: counter increments if taken, decrements if not, saturating at 0 and 3. Target is written only when taken.
  - Miss and taken: allocate the entry (valid=1, new tag, target, counter=2), replacing any occupant.
  - Miss and not taken: no change.
- Reset: pc_o=RESET_PC. All BTB valid bits=0. pend_v=0. Counters and targets are don't-care.

## Timing
- pc_o changes one edge after the accepting condition. A redirect is visible on pc_o on the next cycle.
- A buffered redirect is applied in the cycle fetch_done_i rises (pc_jump_enable_o=1 that cycle), or the first cycle fetch_busy_i=0.
- A BTB update becomes visible to lookup on the following cycle. A same-cycle lookup of the same index sees the old contents.
- Redirect beats stall. Stall never blocks a redirect or a pending apply.
- rst_n deassertion mid-fetch: the block restarts from RESET_PC with no pending redirect.
- With an empty BTB and no redirects, throughput is one PC per fetch_done_i cycle, advancing by +4.

## Test plan
- Reset with RESET_PC=0x100; release; fetch_done_i=1 for 3 cycles -> pc_o 0x100, 0x104, 0x108, 0x10C; pred_taken_o=0 throughout.
- Train with upd pc=0x108, target=0x200, taken -> on the next visit to 0x108, pred_taken_o=1 and pred_pc_o=0x200, and pc_o then becomes 0x200. Two not-taken updates -> pred_taken_o=0 and pred_pc_o=0x10C.
- fetch_busy_i=1, redirect_i to 0x300 while pc_o=0x40 -> pc_o holds 0x40 and pc_jump_enable_o=0. When fetch_done_i=1: pc_jump_enable_o=1 and pc_o=0x300 on the next cycle.
- Pending redirect to 0x300, then redirect_i to 0x400 still while busy -> pc_o=0x400 after completion; 0x300 is never seen.
- stall_i=1 with fetch_done_i=1 -> pc_o holds. Same, plus redirect_i to 0x80 -> pc_o=0x80.
- Aliasing, BTB_ENTRIES=4: train 0x10 taken to 0x50, then 0x20 taken to 0x60 (same index) -> lookup at 0x10 misses and predicts 0x14; rdy=0 during an update -> BTB unchanged.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-address generator: holds the fetch PC, advances it on accepted
// fetches, predicts taken control flow with a direct-mapped BTB of 2-bit
// saturating counters, and buffers redirects that arrive while IF has a
// non-abortable memory fetch outstanding.
module pc_gen #(
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        BTB_ENTRIES = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              stall_i,
  input  logic              fetch_done_i,
  input  logic              fetch_busy_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_taken_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_pc_o,
  output logic              pc_jump_enable_o
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [1:0]        ctr;
  } btb_entry_t;

  // Architectural state
  logic [ADDR_W-1:0]      pc_q, pc_d;
  logic                   pend_v_q, pend_v_d;
  logic [ADDR_W-1:0]      pend_pc_q, pend_pc_d;
  logic [BTB_ENTRIES-1:0] valid_q;
  btb_entry_t             btb_q [BTB_ENTRIES];

  // Lookup path
  logic [IDX_W-1:0]  rd_idx;
  logic [TAG_W-1:0]  rd_tag;
  btb_entry_t        rd_entry;
  logic              rd_hit;
  logic [ADDR_W-1:0] pc_inc;

  // Training path
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  wr_tag;
  btb_entry_t        wr_cur;
  logic              wr_hit;
  logic              wr_en;
  logic              wr_alloc;
  btb_entry_t        wr_entry;

  // Redirect control
  logic acceptable;
  logic jump;

  // Address bits below the word offset never reach the BTB.
  logic unused_low_bits;
  assign unused_low_bits = ^{pc_q[1:0], upd_pc_i[1:0]};

  assign pc_o = pc_q;

  // Combinational BTB lookup on the current fetch PC.
  always_comb begin
    rd_idx       = pc_q[IDX_W+1:2];
    rd_tag       = pc_q[ADDR_W-1:IDX_W+2];
    rd_entry     = btb_q[rd_idx];
    rd_hit       = valid_q[rd_idx] && (rd_entry.tag == rd_tag);
    pc_inc       = pc_q + ADDR_W'(4);
    pred_taken_o = rd_hit && rd_entry.ctr[1];
    pred_pc_o    = pred_taken_o ? rd_entry.target : pc_inc;
  end

  // BTB training decision: counter update on hit, allocate on taken miss.
  always_comb begin
    wr_idx   = upd_pc_i[IDX_W+1:2];
    wr_tag   = upd_pc_i[ADDR_W-1:IDX_W+2];
    wr_cur   = btb_q[wr_idx];
    wr_hit   = valid_q[wr_idx] && (wr_cur.tag == wr_tag);
    wr_en    = 1'b0;
    wr_alloc = 1'b0;
    wr_entry = wr_cur;
    if (rdy && upd_valid_i) begin
      if (wr_hit) begin
        wr_en = 1'b1;
        if (upd_taken_i) begin
          wr_entry.ctr    = (wr_cur.ctr == 2'd3) ? 2'd3 : wr_cur.ctr + 2'd1;
          wr_entry.target = upd_target_i;
        end else begin
          wr_entry.ctr    = (wr_cur.ctr == 2'd0) ? 2'd0 : wr_cur.ctr - 2'd1;
        end
      end else if (upd_taken_i) begin
        wr_en           = 1'b1;
        wr_alloc        = 1'b1;
        wr_entry.tag    = wr_tag;
        wr_entry.target = upd_target_i;
        wr_entry.ctr    = 2'd2;
      end
    end
  end

  // Next-PC selection: redirect, then pending redirect, then advance, else hold.
  always_comb begin
    acceptable = !fetch_busy_i || fetch_done_i;
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_pc_d  = pend_pc_q;
    jump       = 1'b0;
    if (rdy) begin
      if (redirect_i && acceptable) begin
        pc_d     = redirect_pc_i;
        pend_v_d = 1'b0;
        jump     = 1'b1;
      end else if (pend_v_q && acceptable) begin
        pc_d     = pend_pc_q;
        pend_v_d = 1'b0;
        jump     = 1'b1;
      end else if (fetch_done_i && !stall_i && !pend_v_q) begin
        pc_d     = pred_pc_o;
      end
      if (redirect_i && !acceptable) begin
        pend_v_d  = 1'b1;
        pend_pc_d = redirect_pc_i;
      end
    end
  end

  // Jump strobe is combinational and forced low while reset is asserted.
  assign pc_jump_enable_o = jump && rst_n;

  // PC and pending-redirect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      pend_v_q  <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // BTB valid bits; only these need a defined reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_alloc) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // BTB payload (tag, target, counter); contents are ignored until valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      btb_q[wr_idx] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen with a 4-entry BTB and RESET_PC=0x100.
module tb_pc_gen;

  localparam int unsigned BTB_N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy, stall, fdone, fbusy, redir, upd_v, upd_tk;
  logic [31:0] redir_pc, upd_pc, upd_tgt;
  logic [31:0] pc_o, pred_pc_o;
  logic        pred_taken_o, pc_jump_enable_o;

  int total = 0;
  int bad   = 0;

  // Reference model: a PC, a pending slot, and a table of remembered
  // instruction word addresses with target and confidence.
  logic [31:0] m_pc;
  logic        m_pend_v;
  logic [31:0] m_pend_pc;
  logic        m_valid [BTB_N];
  logic [31:0] m_word  [BTB_N];
  logic [31:0] m_tgt   [BTB_N];
  int          m_ctr   [BTB_N];

  pc_gen #(.ADDR_W(32), .BTB_ENTRIES(BTB_N), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .stall_i(stall),
    .fetch_done_i(fdone), .fetch_busy_i(fbusy),
    .redirect_i(redir), .redirect_pc_i(redir_pc),
    .upd_valid_i(upd_v), .upd_pc_i(upd_pc), .upd_target_i(upd_tgt),
    .upd_taken_i(upd_tk),
    .pc_o(pc_o), .pred_taken_o(pred_taken_o), .pred_pc_o(pred_pc_o),
    .pc_jump_enable_o(pc_jump_enable_o)
  );

  always #5 clk = ~clk;

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % BTB_N);
  endfunction

  function automatic logic m_pred_taken();
    int i = slot(m_pc);
    return m_valid[i] && (m_word[i] == (m_pc >> 2)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_pc();
    return m_pred_taken() ? m_tgt[slot(m_pc)] : m_pc + 32'd4;
  endfunction

  function automatic logic m_jump();
    return rst_n && rdy && (!fbusy || fdone) && (redir || m_pend_v);
  endfunction

  task automatic m_reset();
    m_pc = 32'h100;
    m_pend_v = 1'b0;
    m_pend_pc = '0;
    for (int i = 0; i < BTB_N; i++) m_valid[i] = 1'b0;
  endtask

  task automatic idle();
    rdy = 1'b1; stall = 1'b0; fdone = 1'b0; fbusy = 1'b0; redir = 1'b0;
    redir_pc = '0; upd_v = 1'b0; upd_pc = '0; upd_tgt = '0; upd_tk = 1'b0;
  endtask

  // One clock: compute the model's next state from the current inputs,
  // cross the rising edge, and return on the following falling edge.
  task automatic tick();
    logic [31:0] npc = m_pc;
    logic        npv = m_pend_v;
    logic [31:0] nppc = m_pend_pc;
    logic        acc = !fbusy || fdone;
    logic [31:0] pred = m_pred_pc();
    int          i;
    logic        hit;
    if (rdy) begin
      if (redir && acc) begin npc = redir_pc; npv = 1'b0; end
      else if (m_pend_v && acc) begin npc = m_pend_pc; npv = 1'b0; end
      else if (fdone && !stall && !m_pend_v) npc = pred;
      if (redir && !acc) begin npv = 1'b1; nppc = redir_pc; end
    end
    @(posedge clk);
    m_pc = npc; m_pend_v = npv; m_pend_pc = nppc;
    if (rdy && upd_v) begin
      i = slot(upd_pc);
      hit = m_valid[i] && (m_word[i] == (upd_pc >> 2));
      if (hit) begin
        if (upd_tk) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = upd_tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (upd_tk) begin
        m_valid[i] = 1'b1; m_word[i] = upd_pc >> 2;
        m_tgt[i] = upd_tgt; m_ctr[i] = 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 9) != 0) return 32'($urandom_range(0, 31)) << 2;
    return $urandom();
  endfunction

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (pc_o !== 32'h100) begin bad++; $display("FAIL reset_pc: got %h want 00000100", pc_o); end
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL reset_pred: got %b want 0", pred_taken_o); end
    // Buffer a redirect, then reset in the middle of the fetch.
    fbusy = 1'b1; redir = 1'b1; redir_pc = 32'h300;
    #1;
    total++; if (pc_jump_enable_o !== 1'b0) begin bad++; $display("FAIL reset_busy_jump: got %b want 0", pc_jump_enable_o); end
    tick();
    redir = 1'b1; redir_pc = 32'h500; fbusy = 1'b0;
    rst_n = 1'b0; m_reset();
    #1;
    total++; if (pc_jump_enable_o !== 1'b0) begin bad++; $display("FAIL reset_jump_in_reset: got %b want 0", pc_jump_enable_o); end
    total++; if (pc_o !== 32'h100) begin bad++; $display("FAIL reset_async_pc: got %h want 00000100", pc_o); end
    @(negedge clk);
    idle(); rst_n = 1'b1;
    #1;
    total++; if (pc_jump_enable_o !== 1'b0) begin bad++; $display("FAIL reset_pend_cleared: got %b want 0", pc_jump_enable_o); end
    tick();
    #1;
    total++; if (pc_o !== 32'h100) begin bad++; $display("FAIL reset_hold: got %h want 00000100", pc_o); end
  endtask

  task automatic test_sequential();
    do_reset();
    fdone = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (pc_o !== 32'h100 + 32'(4 * k)) begin bad++; $display("FAIL seq_pc%0d: got %h want %h", k, pc_o, 32'h100 + 32'(4 * k)); end
      total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL seq_pred%0d: got %b want 0", k, pred_taken_o); end
      if (k < 3) tick();
    end
  endtask

  task automatic test_train();
    do_reset();
    upd_v = 1'b1; upd_pc = 32'h108; upd_tgt = 32'h200; upd_tk = 1'b1;
    tick();
    upd_v = 1'b0; fdone = 1'b1;
    tick(); tick();
    #1;
    total++; if (pc_o !== 32'h108) begin bad++; $display("FAIL train_reach: got %h want 00000108", pc_o); end
    total++; if (pred_taken_o !== 1'b1) begin bad++; $display("FAIL train_pred: got %b want 1", pred_taken_o); end
    total++; if (pred_pc_o !== 32'h200) begin bad++; $display("FAIL train_target: got %h want 00000200", pred_pc_o); end
    tick();
    fdone = 1'b0;
    #1;
    total++; if (pc_o !== 32'h200) begin bad++; $display("FAIL train_follow: got %h want 00000200", pc_o); end
    redir = 1'b1; redir_pc = 32'h108;
    tick();
    redir = 1'b0; upd_v = 1'b1; upd_pc = 32'h108; upd_tgt = 32'h999; upd_tk = 1'b0;
    #1;
    total++; if (pred_taken_o !== 1'b1) begin bad++; $display("FAIL train_same_cycle_old: got %b want 1", pred_taken_o); end
    tick(); tick();
    upd_v = 1'b0;
    #1;
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL train_nt_pred: got %b want 0", pred_taken_o); end
    total++; if (pred_pc_o !== 32'h10C) begin bad++; $display("FAIL train_nt_pc: got %h want 0000010c", pred_pc_o); end
  endtask

  task automatic test_busy_redirect();
    do_reset();
    redir = 1'b1; redir_pc = 32'h40;
    #1;
    total++; if (pc_jump_enable_o !== 1'b1) begin bad++; $display("FAIL busy_direct_jump: got %b want 1", pc_jump_enable_o); end
    tick();
    fbusy = 1'b1; redir_pc = 32'h300;
    #1;
    total++; if (pc_jump_enable_o !== 1'b0) begin bad++; $display("FAIL busy_jump_blocked: got %b want 0", pc_jump_enable_o); end
    tick();
    redir = 1'b0;
    #1;
    total++; if (pc_o !== 32'h40) begin bad++; $display("FAIL busy_hold: got %h want 00000040", pc_o); end
    tick();
    fdone = 1'b1; stall = 1'b1;
    #1;
    total++; if (pc_jump_enable_o !== 1'b1) begin bad++; $display("FAIL busy_apply_jump: got %b want 1", pc_jump_enable_o); end
    tick();
    fdone = 1'b0; fbusy = 1'b0; stall = 1'b0;
    #1;
    total++; if (pc_o !== 32'h300) begin bad++; $display("FAIL busy_apply_pc: got %h want 00000300", pc_o); end
  endtask

  task automatic test_pending_overwrite();
    do_reset();
    redir = 1'b1; redir_pc = 32'h40;
    tick();
    fbusy = 1'b1; redir_pc = 32'h300;
    tick();
    redir_pc = 32'h400;
    tick();
    redir = 1'b0; fbusy = 1'b0;
    #1;
    total++; if (pc_o !== 32'h40) begin bad++; $display("FAIL ovw_hold: got %h want 00000040", pc_o); end
    total++; if (pc_jump_enable_o !== 1'b1) begin bad++; $display("FAIL ovw_jump: got %b want 1", pc_jump_enable_o); end
    tick();
    #1;
    total++; if (pc_o !== 32'h400) begin bad++; $display("FAIL ovw_pc: got %h want 00000400", pc_o); end
    total++; if (pc_jump_enable_o !== 1'b0) begin bad++; $display("FAIL ovw_cleared: got %b want 0", pc_jump_enable_o); end
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1'b1; fdone = 1'b1;
    tick();
    #1;
    total++; if (pc_o !== 32'h100) begin bad++; $display("FAIL stall_hold: got %h want 00000100", pc_o); end
    redir = 1'b1; redir_pc = 32'h80;
    #1;
    total++; if (pc_jump_enable_o !== 1'b1) begin bad++; $display("FAIL stall_redir_jump: got %b want 1", pc_jump_enable_o); end
    tick();
    redir = 1'b0;
    #1;
    total++; if (pc_o !== 32'h80) begin bad++; $display("FAIL stall_redir_pc: got %h want 00000080", pc_o); end
  endtask

  task automatic test_alias();
    do_reset();
    redir = 1'b1; redir_pc = 32'h10;
    tick();
    redir = 1'b0; upd_v = 1'b1; upd_pc = 32'h10; upd_tgt = 32'h50; upd_tk = 1'b1;
    tick();
    upd_v = 1'b0;
    #1;
    total++; if (pred_pc_o !== 32'h50) begin bad++; $display("FAIL alias_first: got %h want 00000050", pred_pc_o); end
    upd_v = 1'b1; upd_pc = 32'h20; upd_tgt = 32'h60;
    tick();
    upd_v = 1'b0;
    #1;
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL alias_evicted: got %b want 0", pred_taken_o); end
    total++; if (pred_pc_o !== 32'h14) begin bad++; $display("FAIL alias_fallthru: got %h want 00000014", pred_pc_o); end
    rdy = 1'b0; upd_v = 1'b1; upd_pc = 32'h10; upd_tgt = 32'h50; upd_tk = 1'b1;
    redir = 1'b1; redir_pc = 32'h80; fdone = 1'b1;
    #1;
    total++; if (pc_jump_enable_o !== 1'b0) begin bad++; $display("FAIL rdy0_jump: got %b want 0", pc_jump_enable_o); end
    tick();
    idle();
    #1;
    total++; if (pc_o !== 32'h10) begin bad++; $display("FAIL rdy0_pc: got %h want 00000010", pc_o); end
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL rdy0_btb: got %b want 0", pred_taken_o); end
    redir = 1'b1; redir_pc = 32'h20;
    tick();
    redir = 1'b0;
    #1;
    total++; if (pred_pc_o !== 32'h60) begin bad++; $display("FAIL alias_second: got %h want 00000060", pred_pc_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rdy      = ($urandom_range(0, 9) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      fbusy    = ($urandom_range(0, 2) == 0);
      fdone    = ($urandom_range(0, 1) == 0);
      redir    = ($urandom_range(0, 4) == 0);
      redir_pc = rand_pc();
      upd_v    = ($urandom_range(0, 2) == 0);
      upd_pc   = rand_pc();
      upd_tgt  = rand_pc();
      upd_tk   = ($urandom_range(0, 2) != 0);
      #1;
      total++; if (pc_o !== m_pc) begin bad++; $display("FAIL rnd_pc@%0d: got %h want %h", n, pc_o, m_pc); end
      total++; if (pred_taken_o !== m_pred_taken()) begin bad++; $display("FAIL rnd_pred@%0d: got %b want %b", n, pred_taken_o, m_pred_taken()); end
      total++; if (pred_pc_o !== m_pred_pc()) begin bad++; $display("FAIL rnd_predpc@%0d: got %h want %h", n, pred_pc_o, m_pred_pc()); end
      total++; if (pc_jump_enable_o !== m_jump()) begin bad++; $display("FAIL rnd_jump@%0d: got %b want %b", n, pc_jump_enable_o, m_jump()); end
      tick();
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_train();
    test_busy_redirect();
    test_pending_overwrite();
    test_stall();
    test_alias();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
